sine_analyzer: RTL

//  Receive-side companion to the sine generator: consumes 8-bit unsigned samples (ADC or loopback of
//  the generator's DAC byte) and measures one full waveform cycle per result. Detects rising
//  mid-level crossings with hysteresis and reports period, peak, trough and peak-to-peak amplitude
//  per cycle through a valid/ready result port. Sits between the sample source and the checker/display logic.

---
 rtl/sine_pkg.sv | 18 +
 rtl/sine_minmax.sv | 28 ++
 rtl/sine_analyzer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sine_pkg.sv
// Shared definitions for the sine generator / analyzer pair.
// State encodings, default thresholds and sample width.
package sine_pkg;

  localparam int SAMPLE_W = 8;

  localparam logic [SAMPLE_W-1:0] MID_DEF  = 8'h7F;
  localparam logic [SAMPLE_W-1:0] HYST_DEF = 8'h08;

  typedef enum logic [2:0] {
    S_INIT,
    S_HIGH0,
    S_LOW0,
    S_HIGH,
    S_LOW
  } state_t;

endpackage

// File: rtl/sine_minmax.sv
// Running max/min tracker with synchronous restart.
// Restart seeds both extremes with the current sample.
module sine_minmax
  import sine_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                restart,
  input  logic                update,
  input  logic [SAMPLE_W-1:0] din,
  output logic [SAMPLE_W-1:0] vmax,
  output logic [SAMPLE_W-1:0] vmin
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vmax <= '0;
      vmin <= '0;
    end else if (restart) begin
      vmax <= din;
      vmin <= din;
    end else if (update) begin
      if (din > vmax) vmax <= din;
      if (din < vmin) vmin <= din;
    end
  end

endmodule

// File: rtl/sine_analyzer.sv
// Per-cycle waveform measurement: period, peak, trough, amplitude.
// Rising crossings are detected with hysteresis around MID.
module sine_analyzer
  import sine_pkg::*;
#(
  parameter logic [7:0] MID      = MID_DEF,
  parameter logic [7:0] HYST     = HYST_DEF,
  parameter int         PERIOD_W = 16
)(
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          din,
  input  logic                din_valid,
  output logic [PERIOD_W-1:0] period,
  output logic [7:0]          vmax,
  output logic [7:0]          vmin,
  output logic [7:0]          amplitude,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                overrun,
  output logic                no_signal
);

  localparam logic [7:0] TH_HI = MID + HYST;
  localparam logic [7:0] TH_LO = MID - HYST;
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

  state_t state, state_nx;
  logic [PERIOD_W-1:0] cnt;
  logic [7:0] run_max, run_min;
  logic hi, lo, meas, start, emit, tout, accept;

  assign hi     = din >= TH_HI;
  assign lo     = din <= TH_LO;
  assign accept = res_valid & res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (din_valid) begin
      unique case (state)
        S_INIT:
          if (lo)      state_nx = S_LOW0;
          else if (hi) state_nx = S_HIGH0;
        S_HIGH0: if (lo) state_nx = S_LOW0;
        S_LOW0:  if (hi) state_nx = S_HIGH;
        S_HIGH:
          if (tout)    state_nx = S_INIT;
          else if (lo) state_nx = S_LOW;
        S_LOW:
          if (emit)      state_nx = S_HIGH;
          else if (tout) state_nx = S_INIT;
        default: state_nx = S_INIT;
      endcase
    end
  end

  always_comb begin
    meas  = 1'b0;
    start = 1'b0;
    emit  = 1'b0;
    unique case (1'b1)
      (state == S_LOW0): start = din_valid & hi;
      (state == S_LOW): begin
        meas = 1'b1;
        emit = din_valid & hi;
      end
      (state == S_HIGH): meas = 1'b1;
      default: ;
    endcase
    // A crossing on the saturating sample still yields a result
    tout = meas & din_valid & ~emit & (cnt == CNT_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (start | emit) begin
      cnt <= {{(PERIOD_W-1){1'b0}}, 1'b1};
    end else if (tout) begin
      cnt <= '0;
    end else if (meas & din_valid & (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  sine_minmax u_minmax (
    .clk     (clk),
    .rst     (rst),
    .restart (start | emit),
    .update  (meas & din_valid),
    .din     (din),
    .vmax    (run_max),
    .vmin    (run_min)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period    <= '0;
      vmax      <= '0;
      vmin      <= '0;
      amplitude <= '0;
      res_valid <= 1'b0;
      overrun   <= 1'b0;
      no_signal <= 1'b0;
    end else begin
      if (emit) begin
        period    <= cnt;
        vmax      <= run_max;
        vmin      <= run_min;
        amplitude <= run_max - run_min;
        res_valid <= 1'b1;
        no_signal <= 1'b0;
        if (res_valid & ~res_ready) overrun <= 1'b1;
      end else if (accept) begin
        res_valid <= 1'b0;
        overrun   <= 1'b0;
      end
      if (tout) no_signal <= 1'b1;
    end
  end

endmodule
